slave_write_scheduler: RTL
==========================

Name: slave_write_scheduler

Overview:
- Per-slave write-path scheduler; one instance sits in front of each slave port of the 2x2 AXI interconnect.
- Arbitrates AW requests from all masters that decode to this slave, using round-robin.
- Drives the crossbar select/enable for the AW and W channels. W data follows AW grant order; no write interleaving.
- Tracks outstanding writes and routes B responses back by ID MSBs.

Parameters:
- M, 2: number of masters (M >= 2). MW = $clog2(M).
- S, 2: number of slaves. SW = $clog2(S).
- SLAVE_INDEX, 0: this slave's decode value.
- NUM_OUTSTANDING_TRANS, 2: max accepted-but-unresponded writes. Also the order FIFO depth. Must be >= 1.
- ADDR_WIDTH, 32: address width.

Ports:
- clk  in  1  clock
- clr  in  1  reset (asynchronous, active-high)
- AW_valid_f  in  M  per-master AWVALID
- AW_addr_f  in  M*ADDR_WIDTH  per-master AWADDR, master m at [m*ADDR_WIDTH +: ADDR_WIDTH]
- S_AWREADY  in  1  slave AWREADY
- AW_en  out  1  AW path enabled to this slave
- AW_sel  out  MW  master routed on AW
- W_valid_f  in  M  per-master WVALID
- W_last_f  in  M  per-master WLAST
- S_WREADY  in  1  slave WREADY
- W_en  out  1  W path enabled
- W_sel  out  MW  master routed on W
- S_BVALID  in  1  slave BVALID
- S_BID_msb  in  MW  master-index field of slave BID
- B_ready_f  in  M  per-master BREADY
- B_en  out  1  B path enabled
- B_sel  out  MW  master receiving B
- outstanding  out  $clog2(NUM_OUTSTANDING_TRANS+1)  current outstanding count

Behaviour:
- Reset (clr high, async):
  - AW FSM goes to IDLE. AW_en=0, AW_sel=0, W_en=0, W_sel=0, outstanding=0.
  - Order FIFO is emptied (rd/wr pointers=0).
  - last_grant=M-1, so master 0 has first priority.
  - B_en and B_sel are combinational: B_en=S_BVALID, B_sel=S_BID_msb.
  - Reset mid-burst aborts all tracking; no recovery of in-flight state.
- Decode: req[m] = AW_valid_f[m] && AW_addr_f[m][ADDR_WIDTH-1 -: SW] == SLAVE_INDEX.
- AW FSM, state IDLE:
  - Grant is allowed when |req && outstanding < NUM_OUTSTANDING_TRANS.
  - On grant, pick the first req[m] searching from last_grant+1, wrapping modulo M.
  - Register AW_sel=m, AW_en=1, go to GRANT. Arbitration latency is 1 cycle.
  - If no req, or at the outstanding limit, stay in IDLE with AW_en=0.
- AW FSM, state GRANT:
  - Handshake fires when AW_valid_f[AW_sel] && S_AWREADY.
  - On handshake: push AW_sel into the order FIFO, outstanding+1, last_grant=AW_sel, AW_en=0, go to IDLE.
  - Otherwise hold AW_sel and AW_en. A dropped AWVALID is a master protocol violation; the grant is held regardless.
- Throughput: at most one AW acceptance every 2 cycles.
- W routing:
  - W_en = FIFO not empty; W_sel = FIFO head (combinational from registered FIFO state).
  - Beat accepted when W_valid_f[W_sel] && S_WREADY && W_en.
  - Pop only on an accepted beat with W_last_f[W_sel]=1.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Write data arriving before its AW is granted waits; W_en stays 0 while the FIFO is empty.
- FIFO cannot overflow: FIFO count <= outstanding <= NUM_OUTSTANDING_TRANS. Pointers wrap modulo depth.
- Outstanding counter:
  - +1 on AW handshake; -1 on S_BVALID && B_ready_f[S_BID_msb].
  - Both in the same cycle: unchanged.
  - Decrement at 0 saturates at 0 (slave protocol error, ignored).
- No combinational path from inputs to AW_en, AW_sel, W_en or W_sel.

Test Plan:
- Reset then single write: M0 AWADDR decodes to SLAVE_INDEX, S_AWREADY=1.
  -> AW_en=1, AW_sel=0 one cycle after AWVALID; handshake next cycle; outstanding=1.
  -> 4-beat W burst passes with W_sel=0; W_en drops after the WLAST beat.
  -> BVALID with S_BID_msb=0 and B_ready_f[0]=1 -> outstanding=0.
- Contention: M0 and M1 both hold AWVALID continuously, slave always ready, B returned immediately.
  -> grants alternate 0,1,0,1; W_sel follows the same order.
- Outstanding limit: NUM_OUTSTANDING_TRANS=2, no B responses, 3 AW requests.
  -> two grants; third stays blocked with AW_en=0.
  -> one B handshake -> third granted the next cycle.
- Ordering: M1 granted, then M0 granted; M0 asserts WVALID first.
  -> W_sel=1 until M1's WLAST; M0 beats are not accepted before that.
- Simultaneous AW handshake and B handshake at outstanding=1.
  -> outstanding stays 1. Also: a B handshake at outstanding=0 keeps it at 0.
- Assert clr during GRANT with the FIFO holding 2 entries.
  -> AW_en=0, W_en=0, outstanding=0 immediately; after release, master 0 has priority.

Source files
------------

// File: rtl/slave_write_scheduler.sv
// slave_write_scheduler
//   Write-path scheduler placed in front of one slave port of the AXI crossbar.
//   Round-robin arbitrates AW requests from the masters that decode to this
//   slave, steers W data in AW grant order (no interleaving), tracks the number
//   of accepted-but-unresponded writes and steers B responses by BID MSBs.
//
// Ports
//   clk, clr              clock, asynchronous active-high reset
//   AW_valid_f/AW_addr_f  per-master AWVALID / AWADDR (master m at [m*ADDR_WIDTH +: ADDR_WIDTH])
//   S_AWREADY             slave AWREADY
//   AW_en/AW_sel          registered AW crossbar enable / master select
//   W_valid_f/W_last_f    per-master WVALID / WLAST
//   S_WREADY              slave WREADY
//   W_en/W_sel            W crossbar enable / select (head of the order FIFO)
//   S_BVALID/S_BID_msb    slave BVALID and master-index field of BID
//   B_ready_f             per-master BREADY
//   B_en/B_sel            B crossbar enable / select (combinational)
//   outstanding           accepted-but-unresponded write count
//   aw_state_dbg_o        AW FSM state (0 = IDLE, 1 = GRANT)
//
// Handshake: a transfer happens in the cycle where VALID and READY are both
// high at the rising clock edge; VALID never waits on READY.
module slave_write_scheduler #(
  parameter int M                     = 2,
  parameter int S                     = 2,
  parameter int SLAVE_INDEX           = 0,
  parameter int NUM_OUTSTANDING_TRANS = 2,
  parameter int ADDR_WIDTH            = 32,
  localparam int MW = $clog2(M),
  localparam int SW = (S > 1) ? $clog2(S) : 1,
  localparam int OW = $clog2(NUM_OUTSTANDING_TRANS + 1),
  localparam int PW = (NUM_OUTSTANDING_TRANS > 1) ? $clog2(NUM_OUTSTANDING_TRANS) : 1
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [M-1:0]            AW_valid_f,
  input  logic [M*ADDR_WIDTH-1:0] AW_addr_f,
  input  logic                    S_AWREADY,
  output logic                    AW_en,
  output logic [MW-1:0]           AW_sel,
  input  logic [M-1:0]            W_valid_f,
  input  logic [M-1:0]            W_last_f,
  input  logic                    S_WREADY,
  output logic                    W_en,
  output logic [MW-1:0]           W_sel,
  input  logic                    S_BVALID,
  input  logic [MW-1:0]           S_BID_msb,
  input  logic [M-1:0]            B_ready_f,
  output logic                    B_en,
  output logic [MW-1:0]           B_sel,
  output logic [OW-1:0]           outstanding,
  output logic                    aw_state_dbg_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } aw_state_e;

  aw_state_e      state_q, state_d;
  logic [MW-1:0]  aw_sel_q, aw_sel_d;
  logic [MW-1:0]  last_grant_q, last_grant_d;
  logic [OW-1:0]  outstanding_q, outstanding_d;

  // Order FIFO: master indices of granted AWs, in grant order.
  logic [MW-1:0]  fifo_q [NUM_OUTSTANDING_TRANS];
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [OW-1:0]  fifo_cnt_q, fifo_cnt_d;

  logic [M-1:0]   req;
  logic           pick_found;
  logic [MW-1:0]  pick_idx;
  logic [MW-1:0]  cand;
  logic           aw_hs;
  logic           w_pop;
  logic           b_dec;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NUM_OUTSTANDING_TRANS - 1)) ? '0 : p + 1'b1;
  endfunction

  // Address decode: top SW address bits select the slave.
  always_comb begin
    req = '0;
    for (int m = 0; m < M; m++) begin
      req[m] = AW_valid_f[m] &&
               (AW_addr_f[m*ADDR_WIDTH + ADDR_WIDTH-1 -: SW] == SW'(SLAVE_INDEX));
    end
  end

  // Round-robin search starting just after the last granted master.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= M; i++) begin
      cand = MW'((int'(last_grant_q) + i) % M);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // AW FSM next state.
  always_comb begin
    state_d      = state_q;
    aw_sel_d     = aw_sel_q;
    last_grant_d = last_grant_q;
    aw_hs        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found && (outstanding_q < OW'(NUM_OUTSTANDING_TRANS))) begin
          aw_sel_d = pick_idx;
          state_d  = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // The grant is held even if the master drops AWVALID.
        if (AW_valid_f[aw_sel_q] && S_AWREADY) begin
          aw_hs        = 1'b1;
          last_grant_d = aw_sel_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // W routing follows the FIFO head; only a WLAST beat retires the entry.
  assign W_en  = (fifo_cnt_q != '0);
  assign W_sel = fifo_q[rd_ptr_q];
  assign w_pop = W_en && W_valid_f[W_sel] && S_WREADY && W_last_f[W_sel];

  // B steering is purely combinational.
  assign B_en  = S_BVALID;
  assign B_sel = S_BID_msb;
  // A response with nothing outstanding is ignored so the count saturates at 0.
  assign b_dec = S_BVALID && B_ready_f[S_BID_msb] && (outstanding_q != '0);

  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    fifo_cnt_d    = fifo_cnt_q;
    outstanding_d = outstanding_q;
    if (aw_hs) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (w_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({aw_hs, w_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + OW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - OW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    case ({aw_hs, b_dec})
      2'b10:   outstanding_d = outstanding_q + OW'(1);
      2'b01:   outstanding_d = outstanding_q - OW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q       <= ST_IDLE;
      aw_sel_q      <= '0;
      last_grant_q  <= MW'(M - 1);
      outstanding_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      for (int i = 0; i < NUM_OUTSTANDING_TRANS; i++) fifo_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      aw_sel_q      <= aw_sel_d;
      last_grant_q  <= last_grant_d;
      outstanding_q <= outstanding_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      if (aw_hs) fifo_q[wr_ptr_q] <= aw_sel_q;
    end
  end

  assign AW_en          = (state_q == ST_GRANT);
  assign AW_sel         = aw_sel_q;
  assign outstanding    = outstanding_q;
  assign aw_state_dbg_o = state_q;

endmodule
